sobel_edge_detect: RTL and testbench
====================================

# sobel_edge_detect

Downstream consumer of `matrix_generate_3x3` in the Sobel path. On every `matrix_valid` strobe it computes horizontal and vertical Sobel gradients over the 3x3 window and forms the magnitude |Gx|+|Gy|. It then saturates or thresholds the result and emits one edge pixel per window, tagged with raster coordinates, feeding the UART/result-RAM writer.

## Interface
Parameters:
- `IMG_W`, 512, image width in pixels.
- `IMG_H`, 512, image height in pixels.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `matrix_p11`..`matrix_p33`  in  8 each  window pixels; row 1 is top, column 1 is left.
- `matrix_valid`  in  1  one-cycle strobe, driven from upstream `matrix_finish`; the window is sampled on this cycle.
- `thresh_en`  in  1  1 selects binary output, 0 selects saturated magnitude.
- `threshold`  in  8  binarisation level; sampled live at stage 3.
- `edge_pix`  out  8  result pixel.
- `edge_valid`  out  1  one-cycle strobe qualifying `edge_pix`, `edge_x`, `edge_y`.
- `edge_x`  out  $clog2(IMG_W)  column of `edge_pix`.
- `edge_y`  out  $clog2(IMG_H)  row of `edge_pix`.
- `frame_done`  out  1  one-cycle pulse coincident with the last pixel of a frame.

## Operation
- Position counters `x`, `y` advance on each `matrix_valid`.
  - `x` wraps at IMG_W-1 to 0 and increments `y`.
  - `y` wraps at IMG_H-1 to 0.
  - The current `x`/`y` is captured with the window and carried down the pipeline.
- Stage 1 registers four 10-bit unsigned partial sums:
  - `px = p13 + 2*p23 + p33`, `nx = p11 + 2*p21 + p31`
  - `py = p31 + 2*p32 + p33`, `ny = p11 + 2*p12 + p13`
- Stage 2:
  - `Gx = px - nx`, `Gy = py - ny`, 11-bit signed, range ±1020.
  - Registers `ax = |Gx|`, `ay = |Gy|`, 10-bit unsigned.
- Stage 3:
  - `mag = ax + ay`, 11-bit, max 2040.
  - If `thresh_en`: `edge_pix = (mag >= threshold) ? 8'hFF : 8'h00`.
  - Else: `edge_pix = (mag > 255) ? 8'hFF : mag[7:0]`.
- Border rule: when x==0, x==IMG_W-1, y==0 or y==IMG_H-1, `edge_pix` = 0 regardless of mode.
- `frame_done` = 1 with the `edge_valid` whose coordinates are (IMG_W-1, IMG_H-1).
- There is no backpressure; every accepted window produces exactly one output.

## Timing
- Latency is 3 cycles: a `matrix_valid` at cycle N produces `edge_valid` at N+3.
- Throughput is one window per cycle; back-to-back strobes are legal, though upstream delivers one per 3 cycles.
- Gaps between strobes are arbitrary. Pipeline registers hold their values; only the valid shift register advances.
- Reset values: `edge_pix`=0, `edge_valid`=0, `edge_x`=0, `edge_y`=0, `frame_done`=0; all pipeline registers and counters are 0.
- Reset asserted mid-pipeline:
  - On the next edge, all in-flight valids are dropped and the counters return to (0,0).
  - No `edge_valid` appears until 3 cycles after the first post-reset `matrix_valid`.
- `matrix_valid` on the frame-wrap window: counters wrap on the same edge. A strobe on the following cycle is tagged (0,0) of the next frame.
- `threshold`/`thresh_en` changes take effect for any window in stage 3 on that cycle; no synchronisation is required.

## Structure
- Shared include `sobel_defs.vh` holds:
  - `IMG_W`/`IMG_H` defaults, shared with `matrix_generate_3x3`.
  - Partial-sum width (10), gradient width (11), pipeline latency (3).
- One sub-module, `sobel_abs_sum`: purely combinational 11-bit signed abs plus 10-bit add.
  - Instantiated twice, once per axis, in stage 2.
  - Keeps the arithmetic unit-testable.
- The counters, valid shift register and stage-3 output mux stay in the top module.

## Test plan
- Uniform window (all pixels 100) at interior position (5,5), `thresh_en`=0 -> `edge_pix`=0 at N+3.
- Vertical edge: left column 0, right column 255, interior, `thresh_en`=0 -> Gx=1020, Gy=0, mag 1020, `edge_pix`=0xFF.
- p13=p23=p33=10, all others 0, interior:
  - `thresh_en`=0 -> `edge_pix`=40.
  - `thresh_en`=1, `threshold`=40 -> 0xFF.
  - `threshold`=41 -> 0x00.
- Border and frame with IMG_W=IMG_H=4: 16 strobes of the vertical-edge window (one every 3 cycles).
  - Outputs are 0 everywhere except (1,1), (2,1), (1,2), (2,2), which are 0xFF.
  - `frame_done` pulses only with (3,3).
  - Strobe 17 is tagged (0,0).
- Back-to-back strobes for 8 cycles, then a 5-cycle gap -> 8 consecutive `edge_valid`s with correct coordinates and none spurious during the gap.
- `rst_n` low for 1 cycle while 2 windows are in flight -> no `edge_valid` for those windows; the next strobe is tagged (0,0) and appears 3 cycles later.

Source files
------------

// File: rtl/sobel_edge_detect_pkg.sv
// Shared widths, image defaults and the partial-sum helper for the Sobel edge pipeline.
package sobel_edge_detect_pkg;

  localparam int unsigned DefImgW = 512;
  localparam int unsigned DefImgH = 512;
  localparam int unsigned PixW    = 8;
  localparam int unsigned PsumW   = 10;
  localparam int unsigned GradW   = 11;
  localparam int unsigned MagW    = 11;
  localparam int unsigned Latency = 3;

  // a + 2*b + c over one kernel column or row; max 1020 fits PsumW.
  function automatic logic [PsumW-1:0] psum(input logic [PixW-1:0] a,
                                            input logic [PixW-1:0] b,
                                            input logic [PixW-1:0] c);
    return PsumW'(a) + (PsumW'(b) << 1) + PsumW'(c);
  endfunction

endpackage

// File: rtl/sobel_abs_sum.sv
// Combinational gradient for one axis: signed difference of two partial sums, then magnitude.
module sobel_abs_sum
  import sobel_edge_detect_pkg::*;
(
  input  logic [PsumW-1:0] pos_i,
  input  logic [PsumW-1:0] neg_i,
  output logic [PsumW-1:0] abs_o
);

  logic signed [GradW-1:0] grad;

  always_comb begin
    grad  = $signed({1'b0, pos_i}) - $signed({1'b0, neg_i});
    abs_o = grad[GradW-1] ? PsumW'(-grad) : PsumW'(grad);
  end

endmodule

// File: rtl/sobel_edge_detect.sv
// Three-stage Sobel magnitude pipeline with raster tagging, border blanking and thresholding.
module sobel_edge_detect
  import sobel_edge_detect_pkg::*;
#(
  parameter int unsigned IMG_W = DefImgW,
  parameter int unsigned IMG_H = DefImgH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PixW-1:0]          matrix_p11,
  input  logic [PixW-1:0]          matrix_p12,
  input  logic [PixW-1:0]          matrix_p13,
  input  logic [PixW-1:0]          matrix_p21,
  input  logic [PixW-1:0]          matrix_p22,
  input  logic [PixW-1:0]          matrix_p23,
  input  logic [PixW-1:0]          matrix_p31,
  input  logic [PixW-1:0]          matrix_p32,
  input  logic [PixW-1:0]          matrix_p33,
  input  logic                     matrix_valid,
  input  logic                     thresh_en,
  input  logic [PixW-1:0]          threshold,
  output logic [PixW-1:0]          edge_pix,
  output logic                     edge_valid,
  output logic [$clog2(IMG_W)-1:0] edge_x,
  output logic [$clog2(IMG_H)-1:0] edge_y,
  output logic                     frame_done
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

  logic [XW-1:0]        x_q, x_d, x1_q, x1_d, x2_q, x2_d, ex_q, ex_d;
  logic [YW-1:0]        y_q, y_d, y1_q, y1_d, y2_q, y2_d, ey_q, ey_d;
  logic [Latency-2:0]   vld_q, vld_d;
  logic [PsumW-1:0]     px_q, px_d, nx_q, nx_d, py_q, py_d, ny_q, ny_d;
  logic [PsumW-1:0]     ax_q, ax_d, ay_q, ay_d, ax_c, ay_c;
  logic [PixW-1:0]      pix_q, pix_d;
  logic                 ev_q, ev_d, fd_q, fd_d;
  logic [MagW-1:0]      mag;
  logic                 border;

  sobel_abs_sum u_abs_x (
    .pos_i (px_q),
    .neg_i (nx_q),
    .abs_o (ax_c)
  );

  sobel_abs_sum u_abs_y (
    .pos_i (py_q),
    .neg_i (ny_q),
    .abs_o (ay_c)
  );

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    x1_d   = x1_q;
    y1_d   = y1_q;
    x2_d   = x2_q;
    y2_d   = y2_q;
    ex_d   = ex_q;
    ey_d   = ey_q;
    px_d   = px_q;
    nx_d   = nx_q;
    py_d   = py_q;
    ny_d   = ny_q;
    ax_d   = ax_q;
    ay_d   = ay_q;
    pix_d  = pix_q;
    mag    = '0;
    border = 1'b0;
    fd_d   = 1'b0;
    // Only the valid chain advances every cycle; data stages load on their own valid.
    vld_d  = {vld_q[Latency-3:0], matrix_valid};
    ev_d   = vld_q[Latency-2];

    if (matrix_valid) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      x1_d = x_q;
      y1_d = y_q;
      px_d = psum(matrix_p13, matrix_p23, matrix_p33);
      nx_d = psum(matrix_p11, matrix_p21, matrix_p31);
      py_d = psum(matrix_p31, matrix_p32, matrix_p33);
      ny_d = psum(matrix_p11, matrix_p12, matrix_p13);
    end

    if (vld_q[0]) begin
      ax_d = ax_c;
      ay_d = ay_c;
      x2_d = x1_q;
      y2_d = y1_q;
    end

    if (vld_q[1]) begin
      mag    = MagW'(ax_q) + MagW'(ay_q);
      border = (x2_q == '0) || (x2_q == XLast) || (y2_q == '0) || (y2_q == YLast);
      if (border) begin
        pix_d = '0;
      end else if (thresh_en) begin
        pix_d = (mag >= MagW'(threshold)) ? 8'hFF : 8'h00;
      end else begin
        pix_d = (mag > MagW'(255)) ? 8'hFF : mag[PixW-1:0];
      end
      ex_d = x2_q;
      ey_d = y2_q;
      fd_d = (x2_q == XLast) && (y2_q == YLast);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      x1_q  <= '0;
      y1_q  <= '0;
      x2_q  <= '0;
      y2_q  <= '0;
      ex_q  <= '0;
      ey_q  <= '0;
      px_q  <= '0;
      nx_q  <= '0;
      py_q  <= '0;
      ny_q  <= '0;
      ax_q  <= '0;
      ay_q  <= '0;
      pix_q <= '0;
      vld_q <= '0;
      ev_q  <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      x1_q  <= x1_d;
      y1_q  <= y1_d;
      x2_q  <= x2_d;
      y2_q  <= y2_d;
      ex_q  <= ex_d;
      ey_q  <= ey_d;
      px_q  <= px_d;
      nx_q  <= nx_d;
      py_q  <= py_d;
      ny_q  <= ny_d;
      ax_q  <= ax_d;
      ay_q  <= ay_d;
      pix_q <= pix_d;
      vld_q <= vld_d;
      ev_q  <= ev_d;
      fd_q  <= fd_d;
    end
  end

  assign edge_pix   = pix_q;
  assign edge_valid = ev_q;
  assign edge_x     = ex_q;
  assign edge_y     = ey_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Self-checking bench: scoreboard of windows against a kernel-sum reference model.
module tb_sobel_edge_detect;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  typedef struct packed {
    logic [7:0]    pix;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          fd;
    logic [31:0]   cyc;
  } out_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    pin [9];
  logic          matrix_valid = 1'b0;
  logic          thresh_en = 1'b0;
  logic [7:0]    threshold = 8'd0;
  logic [7:0]    edge_pix;
  logic          edge_valid;
  logic [XW-1:0] edge_x;
  logic [YW-1:0] edge_y;
  logic          frame_done;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mx = 0;
  int   my = 0;
  out_t obs_q[$];
  out_t exp_q[$];
  out_t mon;

  sobel_edge_detect #(.IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .matrix_p11   (pin[0]),
    .matrix_p12   (pin[1]),
    .matrix_p13   (pin[2]),
    .matrix_p21   (pin[3]),
    .matrix_p22   (pin[4]),
    .matrix_p23   (pin[5]),
    .matrix_p31   (pin[6]),
    .matrix_p32   (pin[7]),
    .matrix_p33   (pin[8]),
    .matrix_valid (matrix_valid),
    .thresh_en    (thresh_en),
    .threshold    (threshold),
    .edge_pix     (edge_pix),
    .edge_valid   (edge_valid),
    .edge_x       (edge_x),
    .edge_y       (edge_y),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (edge_valid || frame_done) begin
      mon.pix = edge_pix;
      mon.x   = edge_x;
      mon.y   = edge_y;
      mon.fd  = frame_done;
      mon.cyc = cyc;
      obs_q.push_back(mon);
    end
  end

  function automatic logic [71:0] mkwin(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
    logic [71:0] w;
    w = {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    return w;
  endfunction

  // Weighted kernel sums over the window (index r*3+c, row 0 top, col 0 left).
  function automatic logic [7:0] model_pix(input logic [71:0] w, input int x, input int y,
                                           input logic te, input logic [7:0] th);
    int gx, gy, p, wr, wc, mag;
    gx = 0;
    gy = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p  = int'(w[(r*3+c)*8 +: 8]);
        wr = (r == 1) ? 2 : 1;
        wc = (c == 1) ? 2 : 1;
        gx += (c - 1) * wr * p;
        gy += (r - 1) * wc * p;
      end
    end
    mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    if (x == 0 || x == W-1 || y == 0 || y == H-1) return 8'h00;
    if (te) return (mag >= int'(th)) ? 8'hFF : 8'h00;
    if (mag > 255) return 8'hFF;
    return 8'(mag);
  endfunction

  task automatic strobe(input logic [71:0] w);
    out_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) pin[i] = w[i*8 +: 8];
    matrix_valid = 1'b1;
    e.pix = model_pix(w, mx, my, thresh_en, threshold);
    e.x   = XW'(mx);
    e.y   = YW'(my);
    e.fd  = (mx == W-1) && (my == H-1);
    e.cyc = cyc + 3;
    exp_q.push_back(e);
    if (mx == W-1) begin
      mx = 0;
      my = (my == H-1) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      matrix_valid = 1'b0;
      for (int i = 0; i < 9; i++) pin[i] = 8'($urandom_range(0, 255));
    end
  endtask

  function automatic logic [71:0] rand_win(input int spread);
    logic [71:0] w;
    int base;
    base = $urandom_range(0, 255 - spread);
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(base + $urandom_range(0, spread));
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    matrix_valid = 1'b1;
    for (int i = 0; i < 9; i++) pin[i] = 8'($urandom_range(0, 255));
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (edge_pix !== 8'h00) begin
      errors++;
      $display("FAIL reset_pix got %0h want 0", edge_pix);
    end
    checks++;
    if (edge_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %0b want 0", edge_valid);
    end
    checks++;
    if (edge_x !== '0 || edge_y !== '0) begin
      errors++;
      $display("FAIL reset_xy got (%0d,%0d) want (0,0)", edge_x, edge_y);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_fd got %0b want 0", frame_done);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    matrix_valid = 1'b0;
    mx = 0;
    my = 0;
    idle(4);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_spurious got %0d outputs want 0", obs_q.size());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_directed();
    logic [71:0] pw   [10];
    logic        pte  [10];
    logic [7:0]  pth  [10];
    logic [7:0]  pexp [10];
    int          pidx [10];
    pw[0] = mkwin(100, 100, 100, 100, 100, 100, 100, 100, 100);
    pte[0] = 0; pth[0] = 0;  pexp[0] = 8'h00;
    pw[1] = mkwin(0, 0, 255, 0, 0, 255, 0, 0, 255);
    pte[1] = 0; pth[1] = 0;  pexp[1] = 8'hFF;
    pw[2] = mkwin(0, 0, 10, 0, 0, 10, 0, 0, 10);
    pte[2] = 0; pth[2] = 0;  pexp[2] = 8'd40;
    pw[3] = pw[2];
    pte[3] = 1; pth[3] = 40; pexp[3] = 8'hFF;
    pw[4] = pw[2];
    pte[4] = 1; pth[4] = 41; pexp[4] = 8'h00;
    pw[5] = mkwin(10, 0, 0, 10, 0, 0, 10, 0, 0);
    pte[5] = 0; pth[5] = 0;  pexp[5] = 8'd40;
    pw[6] = mkwin(255, 255, 255, 0, 0, 0, 0, 0, 0);
    pte[6] = 0; pth[6] = 0;  pexp[6] = 8'hFF;
    pw[7] = mkwin(0, 0, 5, 0, 0, 0, 0, 0, 0);
    pte[7] = 0; pth[7] = 0;  pexp[7] = 8'd10;
    pw[8] = mkwin(0, 0, 64, 0, 0, 64, 0, 0, 64);
    pte[8] = 0; pth[8] = 0;  pexp[8] = 8'hFF;
    pw[9] = mkwin(0, 0, 64, 0, 0, 63, 0, 0, 64);
    pte[9] = 0; pth[9] = 0;  pexp[9] = 8'hFE;
    for (int k = 0; k < 10; k++) begin
      while (!(mx >= 1 && mx <= W-2 && my >= 1 && my <= H-2)) begin
        strobe(rand_win(255));
        idle(1);
      end
      idle(4);
      thresh_en = pte[k];
      threshold = pth[k];
      pidx[k] = exp_q.size();
      strobe(pw[k]);
      idle(1);
    end
    idle(5);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL dir_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL dir_out%0d got pix=%0h x=%0d y=%0d fd=%0b cyc=%0d want pix=%0h x=%0d y=%0d fd=%0b cyc=%0d",
                   i, obs_q[i].pix, obs_q[i].x, obs_q[i].y, obs_q[i].fd, obs_q[i].cyc,
                   exp_q[i].pix, exp_q[i].x, exp_q[i].y, exp_q[i].fd, exp_q[i].cyc);
        end
      end
    end
    for (int k = 0; k < 10; k++) begin
      if (pidx[k] < obs_q.size()) begin
        checks++;
        if (obs_q[pidx[k]].pix !== pexp[k]) begin
          errors++;
          $display("FAIL dir_pattern%0d got %0h want %0h", k, obs_q[pidx[k]].pix, pexp[k]);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_frame();
    int fdn;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mx = 0;
    my = 0;
    thresh_en = 1'b0;
    for (int s = 0; s < W*H; s++) begin
      strobe(mkwin(0, 0, 255, 0, 0, 255, 0, 0, 255));
      idle(2);
    end
    strobe(mkwin(0, 0, 255, 0, 0, 255, 0, 0, 255));
    idle(5);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL frame_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL frame_out%0d got pix=%0h x=%0d y=%0d fd=%0b cyc=%0d want pix=%0h x=%0d y=%0d fd=%0b cyc=%0d",
                   i, obs_q[i].pix, obs_q[i].x, obs_q[i].y, obs_q[i].fd, obs_q[i].cyc,
                   exp_q[i].pix, exp_q[i].x, exp_q[i].y, exp_q[i].fd, exp_q[i].cyc);
        end
      end
    end
    fdn = 0;
    foreach (obs_q[i]) fdn += int'(obs_q[i].fd);
    checks++;
    if (fdn != 1) begin
      errors++;
      $display("FAIL frame_done_pulses got %0d want 1", fdn);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int rep = 0; rep < 2; rep++) begin
      thresh_en = rep[0];
      threshold = 8'($urandom_range(1, 120));
      for (int s = 0; s < 8; s++) strobe(rand_win(rep == 0 ? 20 : 40));
      idle(5);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL b2b_count rep%0d got %0d want %0d", rep, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        if (i < obs_q.size()) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_out%0d got pix=%0h x=%0d y=%0d fd=%0b cyc=%0d want pix=%0h x=%0d y=%0d fd=%0b cyc=%0d",
                     i, obs_q[i].pix, obs_q[i].x, obs_q[i].y, obs_q[i].fd, obs_q[i].cyc,
                     exp_q[i].pix, exp_q[i].x, exp_q[i].y, exp_q[i].fd, exp_q[i].cyc);
          end
        end
      end
      obs_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic test_midreset();
    strobe(rand_win(255));
    strobe(rand_win(255));
    @(posedge clk);
    #1;
    matrix_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    mx = 0;
    my = 0;
    strobe(rand_win(255));
    idle(5);
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("FAIL midrst_count got %0d want 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL midrst_out got pix=%0h x=%0d y=%0d cyc=%0d want pix=%0h x=%0d y=%0d cyc=%0d",
                 obs_q[0].pix, obs_q[0].x, obs_q[0].y, obs_q[0].cyc,
                 exp_q[0].pix, exp_q[0].x, exp_q[0].y, exp_q[0].cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 9; i++) pin[i] = 8'd0;
    test_reset();
    test_directed();
    test_frame();
    test_back_to_back();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
